// File: rtl/mac_pkg.sv
// Shared constants, sequencer state encoding and the wrap-detect helper used
// by the MAC datapath and its dot-product sequencer.
package mac_pkg;

   localparam int MAC_A_W   = 8;
   localparam int MAC_ACC_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } seq_state_t;

   // An 8x8 product never exceeds 65025, so a single step wraps at most once
   // and the wrapped sum is then strictly below the addend it started from.
   function automatic logic acc_wrapped(input logic [MAC_ACC_W-1:0] y,
                                        input logic [MAC_ACC_W-1:0] c);
      return (y < c);
   endfunction

endpackage

// File: rtl/mac.sv
// Unsigned multiply-accumulate: y = a*b + c (mod 2^16), MAC_LAT register
// stages from inputs to y. Pure datapath, no reset.
module mac
   import mac_pkg::*;
#(
   parameter int MAC_LAT = 1
) (
   input  logic                 clk,
   input  logic [MAC_A_W-1:0]   a,
   input  logic [MAC_A_W-1:0]   b,
   input  logic [MAC_ACC_W-1:0] c,
   output logic [MAC_ACC_W-1:0] y
);

   logic [MAC_ACC_W-1:0] w_prod_p0;
   logic [MAC_ACC_W-1:0] w_sum_p0;
   logic [MAC_ACC_W-1:0] r_y_p [MAC_LAT];

   assign w_prod_p0 = MAC_ACC_W'(a) * MAC_ACC_W'(b);
   assign w_sum_p0  = w_prod_p0 + c;

   // Stage p0 -> p1..pMAC_LAT: shift the sum through the latency pipeline.
   always_ff @(posedge clk) begin
      r_y_p[0] <= w_sum_p0;
      for (int i = 1; i < MAC_LAT; i++) begin
         r_y_p[i] <= r_y_p[i-1];
      end
   end

   assign y = r_y_p[MAC_LAT-1];

endmodule

// File: rtl/mac_dot_seq.sv
// Dot-product sequencer: feeds operand pairs one at a time into a single mac,
// closes the accumulation loop through its own accumulator and returns the
// 16-bit result with a sticky wrap flag on a valid/ready output.
module mac_dot_seq
   import mac_pkg::*;
#(
   parameter int LEN_W   = 8,
   parameter int MAC_LAT = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [LEN_W-1:0]     len,
   input  logic [MAC_ACC_W-1:0] init,
   output logic                 busy,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [MAC_A_W-1:0]   in_a,
   input  logic [MAC_A_W-1:0]   in_b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [MAC_ACC_W-1:0] out_y,
   output logic                 out_ovf
);

   localparam int WAIT_W = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);

   seq_state_t           r_state;
   seq_state_t           w_state_nxt;
   logic [MAC_ACC_W-1:0] r_acc;
   logic                 r_ovf;
   logic [LEN_W-1:0]     r_rem;
   logic [WAIT_W-1:0]    r_wait;
   logic [MAC_A_W-1:0]   r_a_p0;
   logic [MAC_A_W-1:0]   r_b_p0;
   logic [MAC_ACC_W-1:0] r_c_p0;
   logic [MAC_ACC_W-1:0] w_y;
   logic                 w_load;
   logic                 w_accept;
   logic                 w_capture;

   // mac.y is only trusted at the capture edge, so its lack of reset is harmless.
   mac #(.MAC_LAT(MAC_LAT)) u_mac (
      .clk (clk),
      .a   (r_a_p0),
      .b   (r_b_p0),
      .c   (r_c_p0),
      .y   (w_y)
   );

   assign w_load    = (r_state == IDLE) && start;
   assign w_accept  = (r_state == RUN) && in_valid;
   assign w_capture = (r_state == WAIT) && (r_wait == WAIT_W'(MAC_LAT));

   // State register; reset returns to IDLE from anywhere, discarding a job.
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state and handshake outputs.
   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b1;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      unique case (r_state)
         IDLE: begin
            busy = 1'b0;
            if (start) w_state_nxt = (len != '0) ? RUN : DONE;
         end
         RUN: begin
            in_ready = 1'b1;
            if (in_valid) w_state_nxt = WAIT;
         end
         WAIT: begin
            if (w_capture) w_state_nxt = (r_rem == LEN_W'(1)) ? DONE : RUN;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Job control: accumulator, sticky wrap flag, remaining count, wait counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc  <= '0;
         r_ovf  <= 1'b0;
         r_rem  <= '0;
         r_wait <= '0;
      end else if (w_load) begin
         r_acc  <= init;
         r_ovf  <= 1'b0;
         r_rem  <= len;
      end else if (w_accept) begin
         r_wait <= '0;
      end else if (w_capture) begin
         r_acc  <= w_y;
         r_ovf  <= r_ovf | acc_wrapped(w_y, r_c_p0);
         r_rem  <= r_rem - LEN_W'(1);
      end else if (r_state == WAIT) begin
         r_wait <= r_wait + WAIT_W'(1);
      end
   end

   // Stage p0: operand registers that hold the mac inputs for the whole step.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_a_p0 <= in_a;
         r_b_p0 <= in_b;
         r_c_p0 <= r_acc;
      end
   end

   assign out_y   = r_acc;
   assign out_ovf = r_ovf;

endmodule

// File: tb/tb_mac_dot_seq.sv
// Self-checking bench for mac_dot_seq: an independent 17-bit reference model
// feeds a scoreboard that is compared against each result handshake.
module tb_mac_dot_seq;

   localparam int LEN_W   = 8;
   localparam int MAC_LAT = 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [LEN_W-1:0] len;
   logic [15:0]      init;
   logic             busy;
   logic             in_valid;
   logic             in_ready;
   logic [7:0]       in_a;
   logic [7:0]       in_b;
   logic             out_valid;
   logic             out_ready;
   logic [15:0]      out_y;
   logic             out_ovf;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int acc_neg;

   logic [15:0] exp_y_q[$];
   logic        exp_ovf_q[$];
   logic [15:0] m_acc;
   logic        m_ovf;
   int          m_left;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mac_dot_seq #(.LEN_W(LEN_W), .MAC_LAT(MAC_LAT)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .len       (len),
      .init      (init),
      .busy      (busy),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_y     (out_y),
      .out_ovf   (out_ovf)
   );

   // Issue a job from IDLE (called at a negedge) and reset the reference model.
   task automatic start_job(input int l, input int i);
      start  = 1'b1;
      len    = LEN_W'(l);
      init   = 16'(i);
      m_acc  = 16'(i);
      m_ovf  = 1'b0;
      m_left = l;
      if (l == 0) begin
         exp_y_q.push_back(m_acc);
         exp_ovf_q.push_back(m_ovf);
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   // Present one pair until accepted; update the model with a 17-bit sum.
   task automatic send_pair(input int a, input int b);
      int n = 0;
      logic [16:0] s;
      in_valid = 1'b1;
      in_a     = 8'(a);
      in_b     = 8'(b);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!in_ready) begin
         errors++;
         $display("FAIL accept_timeout in_ready=%0d required 1", in_ready);
         in_valid = 1'b0;
         return;
      end
      acc_neg = cyc;
      @(negedge clk);
      in_valid = 1'b0;
      s = {1'b0, m_acc} + 17'(a * b);
      m_ovf = m_ovf | s[16];
      m_acc = s[15:0];
      m_left--;
      if (m_left == 0) begin
         exp_y_q.push_back(m_acc);
         exp_ovf_q.push_back(m_ovf);
      end
   endtask

   // Wait for a result, optionally stall, check it against the scoreboard and
   // complete the handshake (optionally with a simultaneous start).
   task automatic wait_result(input int stall, input int exp_lat, input bit start_at_hs);
      int n = 0;
      logic [15:0] ey;
      logic        eo;
      logic [15:0] y0;
      while (!out_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!out_valid) begin
         errors++;
         $display("FAIL result_timeout out_valid=%0d required 1", out_valid);
         return;
      end
      if (exp_lat >= 0) begin
         checks++;
         if ((cyc - acc_neg) !== exp_lat) begin
            errors++;
            $display("FAIL latency got %0d required %0d", cyc - acc_neg, exp_lat);
         end
      end
      checks++;
      if (exp_y_q.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_empty size=0 required 1");
         return;
      end
      ey = exp_y_q.pop_front();
      eo = exp_ovf_q.pop_front();
      if (out_y !== ey) begin
         errors++;
         $display("FAIL out_y got %0d required %0d", out_y, ey);
      end
      checks++;
      if (out_ovf !== eo) begin
         errors++;
         $display("FAIL out_ovf got %0d required %0d", out_ovf, eo);
      end
      y0 = out_y;
      for (int k = 0; k < stall; k++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || out_y !== y0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold valid=%0d y=%0d ready=%0d required 1 %0d 0",
                     out_valid, out_y, in_ready, y0);
         end
      end
      out_ready = 1'b1;
      if (start_at_hs) begin
         start = 1'b1;
         len   = LEN_W'(2);
         init  = 16'h1234;
      end
      @(negedge clk);
      out_ready = 1'b0;
      start     = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL valid_drop got %0d required 0", out_valid);
      end
      if (start_at_hs) begin
         @(negedge clk);
         checks++;
         if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_at_handshake busy=%0d required 0", busy);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; len = '0; init = '0;
      in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, in_ready, out_valid, out_ovf} !== 4'b0000 || out_y !== 16'd0) begin
         errors++;
         $display("FAIL reset_state busy=%0d rdy=%0d vld=%0d ovf=%0d y=%0d required all 0",
                  busy, in_ready, out_valid, out_ovf, out_y);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset busy=%0d required 0", busy);
      end
   endtask

   task automatic test_back_to_back();
      int first_acc;
      start_job(2, 5);
      send_pair(3, 4);
      first_acc = acc_neg;
      send_pair(10, 2);
      checks++;
      if ((acc_neg - first_acc) !== MAC_LAT + 2) begin
         errors++;
         $display("FAIL throughput got %0d required %0d", acc_neg - first_acc, MAC_LAT + 2);
      end
      wait_result(0, MAC_LAT + 2, 1'b0);
   endtask

   task automatic test_len_zero();
      int  n = 0;
      bit  saw = 1'b0;
      start_job(0, 9);
      while (!out_valid && n < 20) begin
         if (in_ready) saw = 1'b1;
         @(negedge clk);
         n++;
      end
      checks++;
      if (saw !== 1'b0) begin
         errors++;
         $display("FAIL len0_no_ready saw=%0d required 0", saw);
      end
      wait_result(0, -1, 1'b0);
   endtask

   task automatic test_overflow();
      start_job(1, 65000);
      send_pair(255, 255);
      wait_result(0, MAC_LAT + 2, 1'b0);
      start_job(1, 0);
      send_pair(1, 1);
      wait_result(0, MAC_LAT + 2, 1'b0);
   endtask

   task automatic test_gaps_stall();
      start_job(3, 0);
      for (int i = 1; i <= 3; i++) begin
         repeat (2) @(negedge clk);
         if (i == 2) begin
            start = 1'b1; len = LEN_W'(0); init = 16'd123;
            @(negedge clk);
            start = 1'b0;
         end
         send_pair(i, i);
         checks++;
         if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_in_wait got %0d required 0", in_ready);
         end
      end
      wait_result(5, -1, 1'b1);
   endtask

   task automatic test_reset_midjob();
      start_job(4, 0);
      send_pair(5, 6);
      send_pair(7, 8);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({busy, in_ready, out_valid} !== 3'b000 || out_y !== 16'd0) begin
         errors++;
         $display("FAIL midjob_reset busy=%0d rdy=%0d vld=%0d y=%0d required 0 0 0 0",
                  busy, in_ready, out_valid, out_y);
      end
      start_job(1, 1);
      send_pair(2, 3);
      wait_result(0, MAC_LAT + 2, 1'b0);
   endtask

   task automatic test_max_len();
      start_job(255, int'($urandom_range(0, 65535)));
      for (int i = 0; i < 255; i++) begin
         send_pair(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      end
      wait_result(0, MAC_LAT + 2, 1'b0);
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_len_zero();
      test_overflow();
      test_gaps_stall();
      test_reset_midjob();
      test_max_len();
      checks++;
      if (exp_y_q.size() !== 0) begin
         errors++;
         $display("FAIL scoreboard_leftover size=%0d required 0", exp_y_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mac_dot_seq.md
Name: mac_dot_seq

Overview:
- Sequencer that wraps one `mac` instance and computes an unsigned dot product over a stream of 8-bit operand pairs: y = init + sum(a_i*b_i) over N elements.
- It accepts a job (start, length, initial value) and feeds operand pairs into `mac` one at a time.
- It closes the accumulation loop by driving `mac.c` from its own accumulator, then returns the 16-bit result on a valid/ready output.
- Sits between the streaming front-end and any consumer of MAC results; it is the only owner of its `mac` instance.

Parameters:
- LEN_W, 8, width of the job length field; maximum job length is 2^LEN_W-1 elements.
- MAC_LAT, 1, register stages between `mac` inputs and `y`; must match the instantiated `mac`.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  job request; sampled only in IDLE.
- len  in  LEN_W  number of operand pairs; sampled with start.
- init  in  16  initial accumulator value; sampled with start.
- busy  out  1  high in every state except IDLE.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  sequencer can accept an operand pair.
- in_a  in  8  operand a, unsigned.
- in_b  in  8  operand b, unsigned.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_y  out  16  dot-product result, modulo 2^16.
- out_ovf  out  1  sticky: at least one accumulation step of this job wrapped.

Behaviour:
- One clock, clk; reset is synchronous and active-high (rst).
- Reset values: state=IDLE, busy=0, in_ready=0, out_valid=0, out_y=0, out_ovf=0, accumulator=0, element count=0, wait counter=0.
- State IDLE:
  - When start=1, load acc<=init, remaining<=len and clear ovf.
  - Go to RUN if len!=0; otherwise go to DONE with out_y=init and out_ovf=0.
  - When start=0, stay in IDLE.
- State RUN:
  - in_ready=1.
  - On in_valid&&in_ready (edge E0): register a_r<=in_a, b_r<=in_b and c_r<=acc, deassert in_ready, go to WAIT.
  - `mac` inputs are always driven from a_r, b_r, c_r.
- State WAIT:
  - Count MAC_LAT+1 cycles after E0.
  - At edge E(MAC_LAT+1): acc<=mac.y; ovf<=ovf | (mac.y < c_r); remaining<=remaining-1.
  - Then go to DONE if remaining was 1, else go to RUN.
- State DONE:
  - out_valid=1, out_y=acc, out_ovf=ovf; all three are held stable until out_valid&&out_ready.
  - On that handshake go to IDLE and drop out_valid on the next cycle.
- Throughput: one element per MAC_LAT+2 cycles. Latency from the last accepted pair to out_valid is MAC_LAT+2 cycles.
- Arithmetic: unsigned; 8x8 product is at most 65025, so each step wraps at most once and (y < c) detects the wrap exactly.
- start outside IDLE is ignored; it is not queued.
- in_valid outside RUN is ignored; the data is not consumed.
- Gaps in in_valid simply extend RUN; no timeout.
- rst in any state: immediate return to IDLE; an in-flight job and its result are discarded.
- `mac` has no reset, so mac.y is sampled only at the defined WAIT edge and never reaches out_y directly.
- len at maximum (2^LEN_W-1): must complete without counter wrap.
- Simultaneous out_ready and start in DONE: only the handshake is honoured; start must be re-presented in IDLE.

Decomposition:
- Shared package `mac_pkg`:
  - constants MAC_A_W=8, MAC_ACC_W=16.
  - state encoding IDLE/RUN/WAIT/DONE.
- Sub-module: the existing `mac`, instantiated once.
- All sequencing, the accumulator and the wait counter stay in `mac_dot_seq`; no further sub-module.

Test Plan:
- start, len=2, init=5; pairs (3,4),(10,2) streamed back-to-back -> out_y=37, out_ovf=0; out_valid rises exactly 3 cycles after the second accept (MAC_LAT=1).
- start, len=0, init=9 -> DONE with no in_ready pulse; out_y=9, out_ovf=0.
- len=1, init=65000, pair (255,255) -> out_y=64489, out_ovf=1.
- Next job: len=1, init=0, pair (1,1) -> out_ovf=0, confirming ovf is cleared per job.
- len=3, init=0, pairs (1,1),(2,2),(3,3) with 2-cycle in_valid gaps; out_ready held low 5 cycles in DONE:
  - out_y=14, held stable throughout the stall.
  - in_ready stays low while in WAIT and DONE.
  - start pulses during the job are ignored.
- len=4, rst asserted after the 2nd accept:
  - next cycle: busy=0, in_ready=0, out_valid=0.
  - a fresh job len=1, init=1, pair (2,3) -> out_y=7.
